// File: rtl/bram_copy_pkg.sv
// Shared state encoding and default widths for the bram copy engine.
package bram_copy_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH    = 16;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COPY,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/bram_copy_engine.sv
// Word-copy engine mastering both ports of a dual-port bram: reads on port A, writes on port B.
// Optional fill mode (constant pattern instead of port A data) is enabled by BRAM_COPY_FILL_EN.
module bram_copy_engine
  import bram_copy_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned P_ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET,
  input  logic                       I_START,
  input  logic [P_ADDRESS_WIDTH-1:0] I_SRC_ADDRESS,
  input  logic [P_ADDRESS_WIDTH-1:0] I_DST_ADDRESS,
  input  logic [P_ADDRESS_WIDTH:0]   I_LENGTH,
  input  logic                       I_FILL,
  input  logic [P_DATA_WIDTH-1:0]    I_FILL_DATA,
  input  logic [P_DATA_WIDTH-1:0]    I_BRAM_DATA_A,
  output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS_A,
  output logic                       O_BRAM_WRITE_ENABLE_A,
  output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA_A,
  output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS_B,
  output logic                       O_BRAM_WRITE_ENABLE_B,
  output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA_B,
  output logic                       O_BUSY,
  output logic                       O_DONE,
  output logic [P_ADDRESS_WIDTH:0]   O_WORD_COUNT
);

  localparam int unsigned DW = P_DATA_WIDTH;
  localparam int unsigned AW = P_ADDRESS_WIDTH;
  localparam int unsigned LW = AW + 1;

  state_t        state, state_next;
  logic [AW-1:0] addr_a, addr_a_next;
  logic [AW-1:0] addr_b, addr_b_next;
  logic [AW-1:0] dst_ptr, dst_ptr_next;
  logic [LW-1:0] rd_left, rd_left_next;
  logic [LW-1:0] count, count_next;
  logic          we_b, we_b_next;
  logic          busy, busy_next;
  logic          done, done_next;

  // Next-state and next-output logic; the write stage trails the read pointer by one cycle.
  always_comb begin
    state_next   = state;
    addr_a_next  = addr_a;
    addr_b_next  = addr_b;
    dst_ptr_next = dst_ptr;
    rd_left_next = rd_left;
    count_next   = we_b ? count + LW'(1) : count;
    we_b_next    = 1'b0;
    busy_next    = busy;
    done_next    = 1'b0;
    case (state)
      S_IDLE: begin
        if (I_START) begin
          addr_a_next  = I_SRC_ADDRESS;
          dst_ptr_next = I_DST_ADDRESS;
          rd_left_next = I_LENGTH;
          count_next   = '0;
          if (I_LENGTH == '0) begin
            state_next = S_DONE;
          end else begin
            busy_next  = 1'b1;
            state_next = S_COPY;
          end
        end
      end
      S_COPY: begin
        we_b_next    = 1'b1;
        addr_b_next  = dst_ptr;
        dst_ptr_next = dst_ptr + AW'(1);
        rd_left_next = rd_left - LW'(1);
        if (rd_left == LW'(1)) begin
          state_next = S_DRAIN;
        end else begin
          addr_a_next = addr_a + AW'(1);
        end
      end
      S_DRAIN: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state   <= S_IDLE;
      addr_a  <= '0;
      addr_b  <= '0;
      dst_ptr <= '0;
      rd_left <= '0;
      count   <= '0;
      we_b    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      addr_a  <= addr_a_next;
      addr_b  <= addr_b_next;
      dst_ptr <= dst_ptr_next;
      rd_left <= rd_left_next;
      count   <= count_next;
      we_b    <= we_b_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

`ifdef BRAM_COPY_FILL_EN
  logic          fill;
  logic [DW-1:0] fill_data;

  // Fill selection and pattern are captured with the rest of the request.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      fill      <= 1'b0;
      fill_data <= '0;
    end else if (state == S_IDLE && I_START) begin
      fill      <= I_FILL;
      fill_data <= I_FILL_DATA;
    end
  end

  assign O_BRAM_DATA_B = fill ? fill_data : I_BRAM_DATA_A;
`else
  logic unused_fill;
  assign unused_fill   = ^{I_FILL, I_FILL_DATA};
  assign O_BRAM_DATA_B = I_BRAM_DATA_A;
`endif

  assign O_BRAM_ADDRESS_A      = addr_a;
  assign O_BRAM_WRITE_ENABLE_A = 1'b0;
  assign O_BRAM_DATA_A         = '0;
  assign O_BRAM_ADDRESS_B      = addr_b;
  assign O_BRAM_WRITE_ENABLE_B = we_b;
  assign O_BUSY                = busy;
  assign O_DONE                = done;
  assign O_WORD_COUNT          = count;

endmodule

// File: tb/tb_bram_copy_engine.sv
// Directed bench for bram_copy_engine driving a behavioural dual-port bram (read-before-write).
module tb_bram_copy_engine;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [AW:0]   len;
  logic          fill;
  logic [DW-1:0] fill_data;
  logic [DW-1:0] rd_a;
  logic [AW-1:0] addr_a, addr_b;
  logic          we_a, we_b;
  logic [DW-1:0] wd_a, wd_b;
  logic          busy, done;
  logic [AW:0]   word_count;

  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_copy_engine #(.P_DATA_WIDTH(DW), .P_ADDRESS_WIDTH(AW)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_START(start),
    .I_SRC_ADDRESS(src), .I_DST_ADDRESS(dst), .I_LENGTH(len),
    .I_FILL(fill), .I_FILL_DATA(fill_data), .I_BRAM_DATA_A(rd_a),
    .O_BRAM_ADDRESS_A(addr_a), .O_BRAM_WRITE_ENABLE_A(we_a), .O_BRAM_DATA_A(wd_a),
    .O_BRAM_ADDRESS_B(addr_b), .O_BRAM_WRITE_ENABLE_B(we_b), .O_BRAM_DATA_B(wd_b),
    .O_BUSY(busy), .O_DONE(done), .O_WORD_COUNT(word_count)
  );

  // Dual-port bram with 1-cycle read latency plus a bench-side load port.
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else begin
      if (we_a) mem[addr_a] <= wd_a;
      if (we_b) mem[addr_b] <= wd_b;
    end
    rd_a <= mem[addr_a];
  end

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Leaves the bench at the negedge just after the start edge.
  task automatic start_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] l,
                            input logic f, input logic [DW-1:0] fd);
    @(negedge clk);
    src = s; dst = d; len = l; fill = f; fill_data = fd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({addr_a, addr_b, we_a, we_b, wd_a, busy, done, word_count} !== '0) begin
      errors++; $display("FAIL reset_in: outputs=%h required 0", {addr_a, addr_b, we_a, we_b, wd_a, busy, done, word_count});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({addr_a, addr_b, we_b, busy, done, word_count} !== '0) begin
      errors++; $display("FAIL reset_out: outputs=%h required 0", {addr_a, addr_b, we_b, busy, done, word_count});
    end
  endtask

  task automatic test_basic_copy();
    logic [DW-1:0] exp_mem [4] = '{16'h0303, 16'h0002, 16'h0001, 16'h0021};
    start_xfer(10'd0, 10'd100, 11'd4, 1'b0, 16'h0);
    for (int j = 0; j <= 7; j++) begin
      checks++;
      if (we_b !== (j >= 1 && j <= 4)) begin
        errors++; $display("FAIL basic_we j=%0d: got %b required %b", j, we_b, (j >= 1 && j <= 4));
      end
      if (j >= 1 && j <= 4) begin
        checks++;
        if (addr_b !== 10'(100 + j - 1)) begin
          errors++; $display("FAIL basic_addr_b j=%0d: got %0d required %0d", j, addr_b, 100 + j - 1);
        end
      end
      checks++;
      if (done !== (j == 6) || busy !== (j <= 5)) begin
        errors++; $display("FAIL basic_done_busy j=%0d: got %b%b required %b%b", j, done, busy, (j == 6), (j <= 5));
      end
      @(negedge clk);
    end
    checks++;
    if (word_count !== 11'd4) begin
      errors++; $display("FAIL basic_count: got %0d required 4", word_count);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[100 + i] !== exp_mem[i]) begin
        errors++; $display("FAIL basic_mem[%0d]: got %h required %h", 100 + i, mem[100 + i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_ra [3] = '{10'd1021, 10'd1022, 10'd1023};
    logic [AW-1:0] exp_wa [3] = '{10'd1022, 10'd1023, 10'd0};
    logic [DW-1:0] exp_d  [3] = '{16'hC3FD, 16'hC3FE, 16'hC3FF};
    start_xfer(10'd1021, 10'd1022, 11'd3, 1'b0, 16'h0);
    for (int j = 0; j <= 5; j++) begin
      if (j <= 2) begin
        checks++;
        if (addr_a !== exp_ra[j]) begin
          errors++; $display("FAIL wrap_addr_a j=%0d: got %0d required %0d", j, addr_a, exp_ra[j]);
        end
      end
      if (j >= 1 && j <= 3) begin
        checks++;
        if (we_b !== 1'b1 || addr_b !== exp_wa[j-1]) begin
          errors++; $display("FAIL wrap_addr_b j=%0d: got we=%b addr=%0d required we=1 addr=%0d", j, we_b, addr_b, exp_wa[j-1]);
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[exp_wa[i]] !== exp_d[i]) begin
        errors++; $display("FAIL wrap_mem[%0d]: got %h required %h", exp_wa[i], mem[exp_wa[i]], exp_d[i]);
      end
    end
  endtask

  task automatic test_zero_length();
    int we_seen = 0;
    start_xfer(10'd5, 10'd600, 11'd0, 1'b0, 16'h0);
    for (int j = 0; j <= 3; j++) begin
      if (we_b === 1'b1) we_seen++;
      checks++;
      if (done !== (j == 1) || busy !== 1'b0) begin
        errors++; $display("FAIL zero_done j=%0d: got done=%b busy=%b required done=%b busy=0", j, done, busy, (j == 1));
      end
      @(negedge clk);
    end
    checks++;
    if (we_seen != 0 || word_count !== 11'd0) begin
      errors++; $display("FAIL zero_write: got we_cycles=%0d count=%0d required 0 0", we_seen, word_count);
    end
  endtask

  task automatic test_start_while_busy();
    int we_seen = 0;
    logic [DW-1:0] exp_d [3] = '{16'hC3FF, 16'h0002, 16'h0001};
    start_xfer(10'd0, 10'd500, 11'd3, 1'b0, 16'h0);
    for (int j = 0; j <= 6; j++) begin
      if (we_b === 1'b1) we_seen++;
      checks++;
      if (done !== (j == 5)) begin
        errors++; $display("FAIL busy_start_done j=%0d: got %b required %b", j, done, (j == 5));
      end
      if (j == 1) begin
        src = 10'd7; dst = 10'd300; len = 11'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (we_seen != 3 || word_count !== 11'd3) begin
      errors++; $display("FAIL busy_start_count: got we_cycles=%0d count=%0d required 3 3", we_seen, word_count);
    end
    checks++;
    if (mem[300] !== 16'hC12C) begin
      errors++; $display("FAIL busy_start_untouched: got %h required C12C", mem[300]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[500 + i] !== exp_d[i]) begin
        errors++; $display("FAIL busy_start_mem[%0d]: got %h required %h", 500 + i, mem[500 + i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_xfer(10'd0, 10'd400, 11'd8, 1'b0, 16'h0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++;
    if (word_count !== 11'd2 || we_b !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got count=%0d we=%b required 2 1", word_count, we_b);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (we_b !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got we=%b busy=%b required 0 0", we_b, busy);
    end
    @(negedge clk); rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (done !== 1'b0 || we_b !== 1'b0) begin
        errors++; $display("FAIL midrst_idle j=%0d: got done=%b we=%b required 0 0", j, done, we_b);
      end
      @(negedge clk);
    end
    checks++;
    if (mem[400] !== 16'hC3FF || mem[401] !== 16'h0002) begin
      errors++; $display("FAIL midrst_written: got %h %h required C3FF 0002", mem[400], mem[401]);
    end
    for (int i = 2; i < 8; i++) begin
      checks++;
      if (mem[400 + i] !== (16'hC000 ^ 16'(400 + i))) begin
        errors++; $display("FAIL midrst_untouched[%0d]: got %h required %h", 400 + i, mem[400 + i], 16'hC000 ^ 16'(400 + i));
      end
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] exp;
    start_xfer(10'd200, 10'd1020, 11'd4, 1'b1, 16'h00AA);
    for (int j = 0; j <= 7; j++) begin
      if (j == 6) begin
        checks++;
        if (done !== 1'b1) begin
          errors++; $display("FAIL fill_done: got %b required 1", done);
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
`ifdef BRAM_COPY_FILL_EN
      exp = 16'h00AA;
`else
      exp = 16'hC0C8 + 16'(i);
`endif
      checks++;
      if (mem[1020 + i] !== exp) begin
        errors++; $display("FAIL fill_mem[%0d]: got %h required %h", 1020 + i, mem[1020 + i], exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; fill = 1'b0; fill_data = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(i); ld_data = 16'hC000 ^ 16'(i);
    end
    @(negedge clk); ld_en = 1'b0;
    load_word(10'd0, 16'h0303);
    load_word(10'd1, 16'h0002);
    load_word(10'd2, 16'h0001);
    load_word(10'd3, 16'h0021);
    test_reset();
    test_basic_copy();
    test_wrap();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid();
    test_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
